blockarray_writer: RTL and testbench

// - Writer side of the VGA block-array interface. Drives write_strobe / fsm_row_index / fsm_output into the display's blockarray.
// - Owns the game grid: a single-cell block falls, is steered left/right, locks into a stack, and full rows clear.
// - Streams the composed grid (stack OR falling block) to the display, one row per clk, only at frame_start.
// - Sits between the button/update-tick logic and the VGA block-array reader.

---
 rtl/blockarray_writer.sv | 225 ++++++++++++++++++++++
 tb/tb_blockarray_writer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/blockarray_writer.sv
// rtl/blockarray_writer.sv - falling-block game grid owner and row-serial flush writer
//
// Purpose: owns the ROWS x COLS game grid. A single-cell block falls on
// update_tick, is steered by btn_left/btn_right, locks into the stack, and
// full rows are cleared one per cycle. On frame_start, a dirty grid is
// snapshotted (stack OR falling block) and written to the display one row
// per clock.
//
// Ports:
//   clk            system clock
//   reset          asynchronous, active-low reset
//   start          level: 1 = run game, 0 = return to QI
//   update_tick    one gravity step (pulse)
//   btn_left       move block one column left (pulse)
//   btn_right      move block one column right (pulse)
//   frame_start    vertical-blank pulse, launches a flush if dirty
//   write_strobe   fsm_output valid for row fsm_row_index
//   fsm_row_index  row being written
//   fsm_output     row bits, bit c = column c, 1 = lit
//   busy           flush in progress
//   state          QI=00 QPLAY=01 QCLEAR=10 QDONE=11
//   score          rows cleared, saturating at WIN_SCORE

`timescale 1ns/1ps

module blockarray_writer #(
    parameter int ROWS      = 8,
    parameter int COLS      = 8,
    parameter int WIN_SCORE = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    update_tick,
    input  logic                    btn_left,
    input  logic                    btn_right,
    input  logic                    frame_start,
    output logic                    write_strobe,
    output logic [$clog2(ROWS)-1:0] fsm_row_index,
    output logic [COLS-1:0]         fsm_output,
    output logic                    busy,
    output logic [1:0]              state,
    output logic [3:0]              score
);

    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
    localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);
    localparam logic [CW-1:0] MID_COL  = CW'(COLS / 2);
    localparam logic [3:0]    WIN      = 4'(WIN_SCORE);

    typedef enum logic [1:0] {
        QI     = 2'b00,
        QPLAY  = 2'b01,
        QCLEAR = 2'b10,
        QDONE  = 2'b11
    } state_t;

    state_t          st;
    logic [COLS-1:0] grid [ROWS];
    logic [COLS-1:0] snap [ROWS];
    logic [COLS-1:0] composed [ROWS];
    logic [RW-1:0]   blk_row;
    logic [CW-1:0]   blk_col;
    logic            dirty;
    logic            pend_tick;

    logic [COLS-1:0] blk_mask;
    logic            show_blk;
    logic [RW-1:0]   below_row;
    logic [RW-1:0]   next_idx;
    logic [CW-1:0]   left_col;
    logic [CW-1:0]   right_col;
    logic            blocked;
    logic            left_ok;
    logic            right_ok;
    logic            eff_tick;
    logic            full_found;
    logic [RW-1:0]   full_idx;

    assign state = st;

    // The block is not displayed in QI so an idle screen is blank.
    assign show_blk  = (st != QI);
    assign blk_mask  = COLS'(1) << blk_col;
    assign below_row = blk_row + RW'(1);
    assign next_idx  = fsm_row_index + RW'(1);
    assign left_col  = blk_col - CW'(1);
    assign right_col = blk_col + CW'(1);

    // below_row wraps at the bottom row, but that case is caught first.
    assign blocked  = (blk_row == LAST_ROW) || grid[below_row][blk_col];
    assign left_ok  = (blk_col != '0) && !grid[blk_row][left_col];
    assign right_ok = (blk_col != LAST_COL) && !grid[blk_row][right_col];
    assign eff_tick = update_tick || pend_tick;

    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            composed[r] = grid[r] | ((show_blk && blk_row == RW'(r)) ? blk_mask : '0);
        end
    end

    // Later rows overwrite earlier ones, so the lowest full row wins.
    always_comb begin
        full_found = 1'b0;
        full_idx   = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (&grid[r]) begin
                full_found = 1'b1;
                full_idx   = RW'(r);
            end
        end
    end

    // Flush engine and game FSM share one block: the game update is written
    // after the flush launch, so a change in the launch cycle keeps dirty set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st            <= QI;
            score         <= '0;
            write_strobe  <= 1'b0;
            fsm_row_index <= '0;
            fsm_output    <= '0;
            busy          <= 1'b0;
            blk_row       <= '0;
            blk_col       <= MID_COL;
            dirty         <= 1'b1;
            pend_tick     <= 1'b0;
            for (int r = 0; r < ROWS; r++) begin
                grid[r] <= '0;
                snap[r] <= '0;
            end
        end else if (busy) begin
            // Game frozen; remember at most one gravity step.
            if (update_tick) begin
                pend_tick <= 1'b1;
            end
            if (fsm_row_index == LAST_ROW) begin
                busy          <= 1'b0;
                write_strobe  <= 1'b0;
                fsm_row_index <= '0;
                fsm_output    <= '0;
            end else begin
                fsm_row_index <= next_idx;
                fsm_output    <= snap[next_idx];
            end
        end else begin
            if (frame_start && dirty) begin
                busy          <= 1'b1;
                write_strobe  <= 1'b1;
                fsm_row_index <= '0;
                fsm_output    <= composed[0];
                dirty         <= 1'b0;
                for (int r = 0; r < ROWS; r++) begin
                    snap[r] <= composed[r];
                end
            end
            pend_tick <= 1'b0;

            if (!start) begin
                if (st != QI) begin
                    st      <= QI;
                    score   <= '0;
                    blk_row <= '0;
                    blk_col <= MID_COL;
                    dirty   <= 1'b1;
                    for (int r = 0; r < ROWS; r++) begin
                        grid[r] <= '0;
                    end
                end
            end else begin
                case (st)
                    QI: begin
                        st    <= QPLAY;
                        dirty <= 1'b1;
                    end
                    QPLAY: begin
                        if (eff_tick) begin
                            if (blocked) begin
                                grid[blk_row][blk_col] <= 1'b1;
                                st <= QCLEAR;
                            end else begin
                                blk_row <= below_row;
                            end
                            dirty <= 1'b1;
                        end else if (btn_left && !btn_right && left_ok) begin
                            blk_col <= left_col;
                            dirty   <= 1'b1;
                        end else if (btn_right && !btn_left && right_ok) begin
                            blk_col <= right_col;
                            dirty   <= 1'b1;
                        end
                    end
                    QCLEAR: begin
                        if (full_found) begin
                            grid[0] <= '0;
                            for (int r = 1; r < ROWS; r++) begin
                                if (RW'(r) <= full_idx) begin
                                    grid[r] <= grid[r-1];
                                end
                            end
                            if (score != WIN) begin
                                score <= score + 4'd1;
                            end
                            dirty <= 1'b1;
                        end else begin
                            blk_row <= '0;
                            blk_col <= MID_COL;
                            dirty   <= 1'b1;
                            if (grid[0][MID_COL] || score == WIN) begin
                                st <= QDONE;
                            end else begin
                                st <= QPLAY;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_blockarray_writer.sv
// tb/tb_blockarray_writer.sv - directed self-checking bench for blockarray_writer

`timescale 1ns/1ps

module tb_blockarray_writer;

    localparam int ROWS = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       update_tick = 1'b0;
    logic       btn_left = 1'b0;
    logic       btn_right = 1'b0;
    logic       frame_start = 1'b0;
    logic       write_strobe;
    logic [2:0] fsm_row_index;
    logic [7:0] fsm_output;
    logic       busy;
    logic [1:0] state;
    logic [3:0] score;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] cap [ROWS];
    logic [7:0] exp_rows [ROWS];
    int         cap_n;
    int         cap_bad;

    blockarray_writer #(.ROWS(8), .COLS(8), .WIN_SCORE(10)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .update_tick   (update_tick),
        .btn_left      (btn_left),
        .btn_right     (btn_right),
        .frame_start   (frame_start),
        .write_strobe  (write_strobe),
        .fsm_row_index (fsm_row_index),
        .fsm_output    (fsm_output),
        .busy          (busy),
        .state         (state),
        .score         (score)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Pulses frame_start and records strobed rows; optional ticks and a left
    // press are injected at given cycles after the launch (-1 = none).
    task automatic flush_capture(input int tick_a, input int tick_b, input int left_at);
        cap_n   = 0;
        cap_bad = 0;
        for (int r = 0; r < ROWS; r++) cap[r] = '0;
        @(negedge clk);
        frame_start = 1'b1;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            frame_start = 1'b0;
            update_tick = (i == tick_a) || (i == tick_b);
            btn_left    = (i == left_at);
            if (write_strobe === 1'b1) begin
                if (cap_n < ROWS) begin
                    if (busy !== 1'b1 || fsm_row_index !== 3'(cap_n)) cap_bad++;
                    cap[cap_n] = fsm_output;
                end
                cap_n++;
            end else if (busy !== 1'b0 || fsm_row_index !== 3'd0 || fsm_output !== 8'd0) begin
                cap_bad++;
            end
        end
        update_tick = 1'b0;
        btn_left    = 1'b0;
    endtask

    task automatic tick();
        @(negedge clk); update_tick = 1'b1;
        @(negedge clk); update_tick = 1'b0;
        @(negedge clk);
    endtask

    task automatic press(input logic l, input logic r);
        @(negedge clk); btn_left = l; btn_right = r;
        @(negedge clk); btn_left = 1'b0; btn_right = 1'b0;
        @(negedge clk);
    endtask

    task automatic drop_block();
        logic done;
        done = 1'b0;
        for (int k = 0; k < 12 && !done; k++) begin
            @(negedge clk); update_tick = 1'b1;
            @(negedge clk); update_tick = 1'b0;
            if (state !== 2'b01) done = 1'b1;
        end
        vectors++;
        if (!done) begin
            miscompares++;
            $display("FAIL drop_lock: block never locked, state=%b want not 01", state);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        vectors++;
        if ({write_strobe, fsm_row_index, fsm_output, busy, state, score} !== 19'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got ws=%b idx=%0d out=%h busy=%b st=%b sc=%0d want all 0",
                     write_strobe, fsm_row_index, fsm_output, busy, state, score);
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_flush_idle();
        flush_capture(-1, -1, -1);
        exp_rows = '{default: 8'h00};
        vectors++;
        if (cap_n !== 8) begin miscompares++; $display("FAIL t1_count: got %0d strobes want 8", cap_n); end
        vectors++;
        if (cap_bad !== 0) begin miscompares++; $display("FAIL t1_order: got %0d bad cycles want 0", cap_bad); end
        for (int r = 0; r < ROWS; r++) begin
            vectors++;
            if (cap[r] !== exp_rows[r]) begin miscompares++; $display("FAIL t1_row%0d: got %b want %b", r, cap[r], exp_rows[r]); end
        end
        flush_capture(-1, -1, -1);
        vectors++;
        if (cap_n !== 0) begin miscompares++; $display("FAIL t1_clean: got %0d strobes want 0", cap_n); end
    endtask

    task automatic test_fall();
        @(negedge clk); start = 1'b1;
        @(negedge clk);
        vectors++;
        if (state !== 2'b01) begin miscompares++; $display("FAIL t2_state: got %b want 01", state); end
        repeat (3) tick();
        flush_capture(-1, -1, -1);
        exp_rows = '{default: 8'h00};
        exp_rows[3] = 8'b0001_0000;
        vectors++;
        if (cap_n !== 8) begin miscompares++; $display("FAIL t2_count: got %0d strobes want 8", cap_n); end
        for (int r = 0; r < ROWS; r++) begin
            vectors++;
            if (cap[r] !== exp_rows[r]) begin miscompares++; $display("FAIL t2_row%0d: got %b want %b", r, cap[r], exp_rows[r]); end
        end
    endtask

    task automatic test_steer();
        press(1'b0, 1'b1);
        flush_capture(-1, -1, -1);
        vectors++;
        if (cap[3] !== 8'b0010_0000) begin miscompares++; $display("FAIL t3_right: got %b want 00100000", cap[3]); end
        repeat (5) press(1'b1, 1'b0);
        flush_capture(-1, -1, -1);
        vectors++;
        if (cap[3] !== 8'b0000_0001) begin miscompares++; $display("FAIL t3_col0: got %b want 00000001", cap[3]); end
        press(1'b1, 1'b0);
        flush_capture(-1, -1, -1);
        vectors++;
        if (cap_n !== 0) begin miscompares++; $display("FAIL t3_left_edge: got %0d strobes want 0", cap_n); end
        press(1'b1, 1'b1);
        flush_capture(-1, -1, -1);
        vectors++;
        if (cap_n !== 0) begin miscompares++; $display("FAIL t3_both: got %0d strobes want 0", cap_n); end
        press(1'b0, 1'b1);
        flush_capture(-1, -1, -1);
        vectors++;
        if (cap[3] !== 8'b0000_0010) begin miscompares++; $display("FAIL t3_right1: got %b want 00000010", cap[3]); end
    endtask

    task automatic test_clear();
        int cols [7];
        cols = '{0, 1, 2, 3, 5, 6, 7};
        @(negedge clk); start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1;
        repeat (2) @(negedge clk);
        for (int b = 0; b < 7; b++) begin
            if (cols[b] < 4) repeat (4 - cols[b]) press(1'b1, 1'b0);
            else repeat (cols[b] - 4) press(1'b0, 1'b1);
            drop_block();
        end
        flush_capture(-1, -1, -1);
        exp_rows = '{default: 8'h00};
        exp_rows[0] = 8'b0001_0000;
        exp_rows[7] = 8'b1110_1111;
        for (int r = 0; r < ROWS; r++) begin
            vectors++;
            if (cap[r] !== exp_rows[r]) begin miscompares++; $display("FAIL t4_pre_row%0d: got %b want %b", r, cap[r], exp_rows[r]); end
        end
        drop_block();
        vectors++;
        if (state !== 2'b01) begin miscompares++; $display("FAIL t4_state: got %b want 01", state); end
        vectors++;
        if (score !== 4'd1) begin miscompares++; $display("FAIL t4_score: got %0d want 1", score); end
        flush_capture(-1, -1, -1);
        exp_rows = '{default: 8'h00};
        exp_rows[0] = 8'b0001_0000;
        for (int r = 0; r < ROWS; r++) begin
            vectors++;
            if (cap[r] !== exp_rows[r]) begin miscompares++; $display("FAIL t4_post_row%0d: got %b want %b", r, cap[r], exp_rows[r]); end
        end
    endtask

    task automatic test_pend_tick();
        press(1'b0, 1'b1);
        flush_capture(1, 3, 5);
        vectors++;
        if (cap[0] !== 8'b0010_0000) begin miscompares++; $display("FAIL t5_snapshot: got %b want 00100000", cap[0]); end
        vectors++;
        if (cap_n !== 8) begin miscompares++; $display("FAIL t5_count: got %0d strobes want 8", cap_n); end
        flush_capture(-1, -1, -1);
        exp_rows = '{default: 8'h00};
        exp_rows[1] = 8'b0010_0000;
        for (int r = 0; r < ROWS; r++) begin
            vectors++;
            if (cap[r] !== exp_rows[r]) begin miscompares++; $display("FAIL t5_row%0d: got %b want %b", r, cap[r], exp_rows[r]); end
        end
    endtask

    task automatic test_stack_done();
        press(1'b1, 1'b0);
        repeat (8) drop_block();
        vectors++;
        if (state !== 2'b11) begin miscompares++; $display("FAIL t6_state: got %b want 11", state); end
        vectors++;
        if (score !== 4'd1) begin miscompares++; $display("FAIL t6_score: got %0d want 1", score); end
        flush_capture(-1, -1, -1);
        for (int r = 0; r < ROWS; r++) begin
            vectors++;
            if (cap[r] !== 8'b0001_0000) begin miscompares++; $display("FAIL t6_row%0d: got %b want 00010000", r, cap[r]); end
        end
        tick();
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        flush_capture(-1, -1, -1);
        vectors++;
        if (cap_n !== 0) begin miscompares++; $display("FAIL t6_frozen: got %0d strobes want 0", cap_n); end
        vectors++;
        if (score !== 4'd1 || state !== 2'b11) begin
            miscompares++;
            $display("FAIL t6_hold: got score=%0d state=%b want 1 11", score, state);
        end
    endtask

    task automatic test_reset_midflush();
        logic found;
        @(negedge clk); start = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (state !== 2'b00) begin miscompares++; $display("FAIL t6_qi: got %b want 00", state); end
        frame_start = 1'b1;
        @(negedge clk); frame_start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            if (write_strobe === 1'b1 && fsm_row_index === 3'd3) found = 1'b1;
            else @(negedge clk);
        end
        vectors++;
        if (!found) begin miscompares++; $display("FAIL t6_row3: got no row-3 strobe want one"); end
        reset = 1'b0;
        #1;
        vectors++;
        if (write_strobe !== 1'b0 || busy !== 1'b0 || state !== 2'b00 || fsm_row_index !== 3'd0) begin
            miscompares++;
            $display("FAIL t6_async: got ws=%b busy=%b st=%b idx=%0d want 0 0 00 0",
                     write_strobe, busy, state, fsm_row_index);
        end
        @(negedge clk); reset = 1'b1;
        flush_capture(-1, -1, -1);
        vectors++;
        if (cap_n !== 8) begin miscompares++; $display("FAIL t6_reflush: got %0d strobes want 8", cap_n); end
        vectors++;
        if (cap[0] !== 8'd0) begin miscompares++; $display("FAIL t6_reflush_row0: got %b want 00000000", cap[0]); end
    endtask

    initial begin
        test_reset();
        test_flush_idle();
        test_fall();
        test_steer();
        test_clear();
        test_pend_tick();
        test_stack_done();
        test_reset_midflush();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
